// File: rtl/bht_sat_predictor.sv
// Branch history table: NR_ENTRIES two-bit saturating counters with a valid bit,
// indexed by PC bits [ROW_OFFSET +: log2(NR_ENTRIES)], no tags.
// The array has no reset so it can map to LUTRAM; it is cleared instead by a sweep
// that writes one entry per cycle after reset or flush_bp_i.
// Prediction outputs are registered (one cycle latency from vpc_i).
// Optional feature macro: BHT_UPDATE_BYPASS_EN -- when defined, a prediction read of
// the index being trained in the same cycle returns the post-update entry; when
// undefined the read returns the pre-update entry (read-before-write).

module bht_sat_predictor #(
  parameter int unsigned NR_ENTRIES = 128,
  parameter int unsigned VLEN       = 32,
  parameter int unsigned ROW_OFFSET = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  output logic            bht_valid_o,
  output logic            bht_taken_o,
  input  logic            update_valid_i,
  input  logic [VLEN-1:0] update_pc_i,
  input  logic            update_taken_i,
  output logic            ready_o
);

  localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_ENTRIES - 1);

  // Counter value written to every entry by the sweep: weakly not-taken.
  localparam logic [1:0] CNT_RESET = 2'b01;

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] clr_idx_q;
  logic             ready_q;

  // Storage array, deliberately without reset.
  logic             valid_q [NR_ENTRIES];
  logic [1:0]       cnt_q   [NR_ENTRIES];

  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] upd_idx;

  logic             upd_we;
  logic             upd_old_valid;
  logic [1:0]       upd_old_cnt;
  logic             upd_new_valid;
  logic [1:0]       upd_new_cnt;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic             wvalid;
  logic [1:0]       wcnt;

  logic             rd_valid;
  logic [1:0]       rd_cnt;

  logic             bht_valid_q;
  logic             bht_taken_q;

  assign pred_idx = vpc_i[ROW_OFFSET+IDX_W-1:ROW_OFFSET];
  assign upd_idx  = update_pc_i[ROW_OFFSET+IDX_W-1:ROW_OFFSET];

  // PC bits outside the index field are intentionally ignored (aliasing accepted).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:ROW_OFFSET+IDX_W], vpc_i[ROW_OFFSET-1:0],
                            update_pc_i[VLEN-1:ROW_OFFSET+IDX_W],
                            update_pc_i[ROW_OFFSET-1:0]};

  // Sweep/idle control: counts clr_idx through the array, then opens the table.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        StClear: begin
          if (flush_bp_i) begin
            clr_idx_q <= '0;
          end else if (clr_idx_q == LAST_IDX) begin
            state_q   <= StIdle;
            clr_idx_q <= '0;
            ready_q   <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        StIdle: begin
          if (flush_bp_i) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= StClear;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = ready_q;

  // Training is dropped while sweeping, in debug mode, or when a flush arrives.
  assign upd_we = (state_q == StIdle) & update_valid_i & ~debug_mode_i & ~flush_bp_i;

  // Read-modify-write of the trained entry: first touch seeds weak taken/not-taken,
  // later touches move the counter one step with saturation.
  always_comb begin
    upd_old_valid = valid_q[upd_idx];
    upd_old_cnt   = cnt_q[upd_idx];
    upd_new_valid = 1'b1;
    upd_new_cnt   = upd_old_cnt;
    if (!upd_old_valid) begin
      upd_new_cnt = update_taken_i ? 2'b10 : 2'b01;
    end else if (update_taken_i) begin
      if (upd_old_cnt != 2'b11) begin
        upd_new_cnt = upd_old_cnt + 2'd1;
      end
    end else begin
      if (upd_old_cnt != 2'b00) begin
        upd_new_cnt = upd_old_cnt - 2'd1;
      end
    end
  end

  // Single write port shared between the clearing sweep and training.
  always_comb begin
    we     = 1'b0;
    waddr  = upd_idx;
    wvalid = upd_new_valid;
    wcnt   = upd_new_cnt;
    if (state_q == StClear) begin
      we     = 1'b1;
      waddr  = clr_idx_q;
      wvalid = 1'b0;
      wcnt   = CNT_RESET;
    end else begin
      we     = upd_we;
    end
  end

  // Array write port.
  always_ff @(posedge clk_i) begin
    if (we) begin
      valid_q[waddr] <= wvalid;
      cnt_q[waddr]   <= wcnt;
    end
  end

`ifdef BHT_UPDATE_BYPASS_EN
  // Prediction read with forwarding of a same-cycle update to the same index.
  always_comb begin
    rd_valid = valid_q[pred_idx];
    rd_cnt   = cnt_q[pred_idx];
    if (upd_we && (upd_idx == pred_idx)) begin
      rd_valid = upd_new_valid;
      rd_cnt   = upd_new_cnt;
    end
  end
`else
  // Prediction read, read-before-write against a same-cycle update.
  always_comb begin
    rd_valid = valid_q[pred_idx];
    rd_cnt   = cnt_q[pred_idx];
  end
`endif

  // Registered prediction; forced to zero while the table is being swept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bht_valid_q <= 1'b0;
      bht_taken_q <= 1'b0;
    end else if (state_q == StIdle) begin
      bht_valid_q <= rd_valid;
      bht_taken_q <= rd_cnt[1];
    end else begin
      bht_valid_q <= 1'b0;
      bht_taken_q <= 1'b0;
    end
  end

  assign bht_valid_o = bht_valid_q;
  assign bht_taken_o = bht_taken_q;

endmodule
